// File: rtl/uart_pkg.sv
// Shared types, default generics and FSM state encoding for the UART vector link.
// Build option: define UART_PARITY_EN to add an even-parity bit to every frame.
package uart_pkg;

  typedef logic signed [15:0] num;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_WORD_W       = 16;
  localparam int DEF_N_TX         = 5;
  localparam int DEF_N_RX         = 5;
  localparam int DEF_IDLE_BITS    = 20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } uart_state_e;

  // State entered after the eighth data bit of a frame.
`ifdef UART_PARITY_EN
  localparam uart_state_e ST_AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e ST_AFTER_DATA = ST_STOP;
`endif

endpackage

// File: rtl/uart_byte_rx.sv
// Single-byte UART receiver: synchroniser, start validation, bit sampling, stop/parity check.
// Build option: UART_PARITY_EN expects an even-parity bit before the stop bit.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       idle
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_meta, rx_sync, rx_prev;
  logic             half_tick, bit_tick, stop_ok;
`ifdef UART_PARITY_EN
  logic             par_bit;
`endif

  assign half_tick = (cnt == HALF_LAST);
  assign bit_tick  = (cnt == BIT_LAST);
`ifdef UART_PARITY_EN
  assign stop_ok   = rx_sync && (par_bit == ^shift);
`else
  assign stop_ok   = rx_sync;
`endif

  assign byte_valid = (state == ST_STOP) && bit_tick && stop_ok;
  assign frame_err  = ((state == ST_START) && half_tick && rx_sync) ||
                      ((state == ST_STOP) && bit_tick && !stop_ok);
  assign byte_data  = shift;
  assign idle       = (state == ST_IDLE);

  // Synchroniser resets to the idle level so reset release never looks like a start edge.
  // NOTE: flops are written with non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) state <= ST_START;
        end
        ST_START: if (half_tick) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rx_sync ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (bit_tick) begin
          cnt     <= '0;
          shift   <= {rx_sync, shift[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= ST_AFTER_DATA;
        end
`ifdef UART_PARITY_EN
        ST_PARITY: if (bit_tick) begin
          cnt     <= '0;
          par_bit <= rx_sync;
          state   <= ST_STOP;
        end
`endif
        // Leaving at the stop-bit centre; a low line after a framing error cannot retrigger.
        ST_STOP: if (bit_tick) begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_vector_link.sv
// Full-duplex UART moving whole vectors of signed words; TX FSM, RX vector assembly, idle timeout.
// Build option: UART_PARITY_EN adds an even-parity bit to every TX and RX frame.
module uart_vector_link
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int WORD_W       = DEF_WORD_W,
  parameter int N_TX         = DEF_N_TX,
  parameter int N_RX         = DEF_N_RX,
  parameter int IDLE_BITS    = DEF_IDLE_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   send_data,
  input  logic [N_TX*WORD_W-1:0] tx_nums,
  output logic                   tx_ready,
  output logic                   tx,
  input  logic                   rx,
  output logic [N_RX*WORD_W-1:0] rx_nums,
  output logic                   rx_available,
  output logic                   rx_error
);

  localparam int TX_BITS   = N_TX * WORD_W;
  localparam int TX_BYTES  = TX_BITS / 8;
  localparam int RX_BITS   = N_RX * WORD_W;
  localparam int RX_BYTES  = RX_BITS / 8;
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int TXI_W     = $clog2(TX_BYTES + 1);
  localparam int RXI_W     = $clog2(RX_BYTES + 1);
  localparam int TO_CYCLES = IDLE_BITS * CLKS_PER_BIT;
  localparam int TO_W      = $clog2(TO_CYCLES);
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TXI_W-1:0] TX_LAST_BYTE = TXI_W'(TX_BYTES - 1);
  localparam logic [RXI_W-1:0] RX_LAST_BYTE = RXI_W'(RX_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST      = TO_W'(TO_CYCLES - 1);

  uart_state_e      tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [TXI_W-1:0] tx_byte;
  logic [TX_BITS-1:0] tx_buf;
  logic [7:0]       tx_lo;
  logic             tx_tick, tx_load, tx_shift;

  assign tx_tick  = (tx_cnt == BIT_LAST);
  assign tx_ready = (tx_state == ST_IDLE);
  assign tx_load  = tx_ready && send_data;
  assign tx_shift = (tx_state == ST_STOP) && tx_tick;
  assign tx_lo    = tx_buf[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
    end else begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        ST_IDLE: begin
          tx_cnt <= '0;
          if (send_data) begin
            tx_byte  <= '0;
            tx_state <= ST_START;
          end
        end
        ST_START: if (tx_tick) begin
          tx_bit   <= '0;
          tx_state <= ST_DATA;
        end
        ST_DATA: if (tx_tick) begin
          tx_bit <= tx_bit + 1'b1;
          if (tx_bit == 3'd7) tx_state <= ST_AFTER_DATA;
        end
`ifdef UART_PARITY_EN
        ST_PARITY: if (tx_tick) tx_state <= ST_STOP;
`endif
        ST_STOP: if (tx_tick) begin
          if (tx_byte == TX_LAST_BYTE) begin
            tx_state <= ST_IDLE;
          end else begin
            tx_byte  <= tx_byte + 1'b1;
            tx_state <= ST_START;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: pure data registers carry no reset; they are always loaded before being used.
  always_ff @(posedge clk) begin
    if (tx_load)       tx_buf <= tx_nums;
    else if (tx_shift) tx_buf <= tx_buf >> 8;
  end

  // Decoded from state so an asynchronous reset returns the line high immediately.
  always_comb begin
    tx = 1'b1;
    case (tx_state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = tx_lo[tx_bit];
`ifdef UART_PARITY_EN
      ST_PARITY: tx = ^tx_lo;
`endif
      default:   tx = 1'b1;
    endcase
  end

  logic             byte_valid, frame_err, rx_idle, timeout;
  logic [7:0]       byte_data;
  logic [RXI_W-1:0] rx_byte;
  logic [TO_W-1:0]  idle_cnt;
  logic [RX_BITS-1:0] shadow, shadow_next;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .idle      (rx_idle)
  );

  // NOTE: the default copy first keeps every path assigned, so no latch is inferred.
  always_comb begin
    shadow_next = shadow;
    for (int k = 0; k < RX_BYTES; k++) begin
      if (rx_byte == RXI_W'(k)) shadow_next[8*k +: 8] = byte_data;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_valid) shadow <= shadow_next;
  end

  assign timeout = (rx_byte != '0) && rx_idle && (idle_cnt == TO_LAST);

  // Errors only arise outside STOP-accept and timeouts only while idle, so they never meet a completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_byte      <= '0;
      idle_cnt     <= '0;
      rx_nums      <= '0;
      rx_available <= 1'b0;
      rx_error     <= 1'b0;
    end else begin
      rx_available <= 1'b0;
      rx_error     <= frame_err || timeout;
      idle_cnt     <= ((rx_byte != '0) && rx_idle && !timeout) ? idle_cnt + 1'b1 : '0;
      if (frame_err || timeout) begin
        rx_byte <= '0;
      end else if (byte_valid) begin
        if (rx_byte == RX_LAST_BYTE) begin
          rx_byte      <= '0;
          rx_nums      <= shadow_next;
          rx_available <= 1'b1;
        end else begin
          rx_byte <= rx_byte + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_vector_link.sv
// Directed bench for uart_vector_link at 16 clocks per bit, loopback and host-driven RX.
// Build option: UART_PARITY_EN enables the parity scenario and 11-bit frames.
module tb_uart_vector_link;
  import uart_pkg::*;

  localparam int CPB   = 16;
  localparam int N     = 5;
  localparam int VEC_W = N * 16;
  localparam int BYTES = VEC_W / 8;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int BIT_T = CPB * 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic send_data = 1'b0;
  logic host_rx = 1'b1;
  logic loop_en = 1'b0;
  logic rx, tx, tx_ready, rx_available, rx_error;
  logic [VEC_W-1:0] tx_nums = '0;
  logic [VEC_W-1:0] rx_nums;

  int checks = 0;
  int failures = 0;
  int avail_cnt = 0;
  int err_cnt = 0;
  int a0, e0, n;
  logic [7:0] tx_q[$];
  logic [7:0] mon_b;
  logic [7:0] first_b;
  logic [VEC_W-1:0] v1, v2, v3;

  uart_vector_link #(
    .CLKS_PER_BIT(CPB), .WORD_W(16), .N_TX(N), .N_RX(N), .IDLE_BITS(20)
  ) dut (
    .clk(clk), .reset(reset), .send_data(send_data), .tx_nums(tx_nums),
    .tx_ready(tx_ready), .tx(tx), .rx(rx), .rx_nums(rx_nums),
    .rx_available(rx_available), .rx_error(rx_error)
  );

  always #5 clk = ~clk;
  assign rx = loop_en ? tx : host_rx;

  always @(negedge clk) begin
    if (rx_available === 1'b1) avail_cnt++;
    if (rx_error === 1'b1) err_cnt++;
  end

  // Independent line decoder for the TX pin.
  initial begin
    forever begin
      @(negedge tx);
      #(BIT_T / 2 + 3);
      if (tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          #(BIT_T);
          mon_b[i] = tx;
        end
        #(BIT_T * (FRAME_BITS - 9));
        tx_q.push_back(mon_b);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [VEC_W-1:0] vec_of(input num w);
    return {N{w}};
  endfunction

  task automatic wait_cycles(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic host_bit(input logic v);
    host_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic host_byte(input logic [7:0] b, input logic stop_bit, input logic bad_par);
    logic [10:0] frame;
    frame = {stop_bit, (^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 9; i++) host_bit(frame[i]);
`ifdef UART_PARITY_EN
    host_bit(frame[9]);
`endif
    host_bit(frame[10]);
    host_rx = 1'b1;
  endtask

  task automatic host_vector(input logic [VEC_W-1:0] v);
    for (int i = 0; i < BYTES; i++) host_byte(v[8*i +: 8], 1'b1, 1'b0);
  endtask

  task automatic pulse_send();
    @(negedge clk) send_data = 1'b1;
    @(negedge clk) send_data = 1'b0;
  endtask

  task automatic test_reset();
    logic disturbed;
    reset = 1'b1;
    wait_cycles(3);
    checks++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || rx_available !== 1'b0 || rx_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs tx=%b ready=%b avail=%b err=%b expected 1 1 0 0",
               tx, tx_ready, rx_available, rx_error);
    end
    reset = 1'b0;
    a0 = avail_cnt; e0 = err_cnt; disturbed = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1) disturbed = 1'b1;
    end
    checks++;
    if (disturbed !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold tx or tx_ready left idle level during 2000 cycles");
    end
    checks++;
    if (rx_nums !== '0) begin
      failures++;
      $display("FAIL reset_rx_nums got=%h expected 0", rx_nums);
    end
    checks++;
    if (avail_cnt - a0 !== 0 || err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL idle_pulses avail=%0d err=%0d expected 0 0", avail_cnt - a0, err_cnt - e0);
    end
  endtask

  task automatic test_loopback();
    loop_en = 1'b1;
    tx_q.delete();
    a0 = avail_cnt; e0 = err_cnt;
    v1 = {16'hF6A5, 16'hFEDA, 16'hFD3C, 16'h00C1, 16'hDABE};
    tx_nums = v1;
    pulse_send();
    n = 0;
    while (tx_ready !== 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    wait_cycles(4 * CPB);
    checks++;
    if (n !== BYTES * FRAME_BITS * CPB) begin
      failures++;
      $display("FAIL loop_ready_low got=%0d expected %0d", n, BYTES * FRAME_BITS * CPB);
    end
    checks++;
    if (avail_cnt - a0 !== 1 || err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL loop_pulses avail=%0d err=%0d expected 1 0", avail_cnt - a0, err_cnt - e0);
    end
    checks++;
    if (rx_nums !== v1) begin
      failures++;
      $display("FAIL loop_rx_nums got=%h expected %h", rx_nums, v1);
    end
    first_b = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
    checks++;
    if (tx_q.size() !== BYTES || first_b !== 8'hBE) begin
      failures++;
      $display("FAIL loop_line_bytes count=%0d first=%h expected %0d BE", tx_q.size(), first_b, BYTES);
    end
  endtask

  task automatic test_back_to_back_ignore();
    logic bad;
    tx_q.delete();
    a0 = avail_cnt;
    v2 = {16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h55AA};
    v3 = ~v2;
    tx_nums = v2;
    pulse_send();
    n = 0;
    while (tx_ready !== 1'b1 && n < 5000) begin
      if (n == 100) begin
        tx_nums = v3;
        send_data = 1'b1;
      end else begin
        send_data = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    send_data = 1'b0;
    wait_cycles(4 * CPB);
    checks++;
    if (n !== BYTES * FRAME_BITS * CPB) begin
      failures++;
      $display("FAIL ignore_ready_low got=%0d expected %0d", n, BYTES * FRAME_BITS * CPB);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL ignore_no_restart tx_ready=%b expected 1", tx_ready);
    end
    bad = (tx_q.size() != BYTES);
    for (int i = 0; i < BYTES && i < tx_q.size(); i++) if (tx_q[i] !== v2[8*i +: 8]) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL ignore_line_bytes count=%0d first=%h expected %0d bytes of %h",
               tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx, BYTES, v2);
    end
    checks++;
    if (rx_nums !== v2 || avail_cnt - a0 !== 1) begin
      failures++;
      $display("FAIL ignore_rx got=%h avail=%0d expected %h 1", rx_nums, avail_cnt - a0, v2);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_framing();
    a0 = avail_cnt; e0 = err_cnt;
    for (int i = 0; i < 3; i++) host_byte(8'h11, 1'b1, 1'b0);
    host_byte(8'h22, 1'b0, 1'b0);
    host_bit(1'b1);
    host_bit(1'b1);
    checks++;
    if (err_cnt - e0 !== 1 || avail_cnt - a0 !== 0) begin
      failures++;
      $display("FAIL framing_err err=%0d avail=%0d expected 1 0", err_cnt - e0, avail_cnt - a0);
    end
    host_vector(vec_of(16'sh1234));
    wait_cycles(2 * CPB);
    checks++;
    if (avail_cnt - a0 !== 1 || err_cnt - e0 !== 1 || rx_nums !== vec_of(16'sh1234)) begin
      failures++;
      $display("FAIL framing_recover avail=%0d err=%0d rx=%h expected 1 1 %h",
               avail_cnt - a0, err_cnt - e0, rx_nums, vec_of(16'sh1234));
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) host_byte(8'hA5, 1'b1, 1'b0);
    a0 = avail_cnt; e0 = err_cnt;
    wait_cycles(18 * CPB);
    checks++;
    if (err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL timeout_early err=%0d expected 0", err_cnt - e0);
    end
    wait_cycles(4 * CPB);
    checks++;
    if (err_cnt - e0 !== 1) begin
      failures++;
      $display("FAIL timeout_err err=%0d expected 1", err_cnt - e0);
    end
    v1 = {16'h8001, 16'h4002, 16'h2003, 16'h1004, 16'h0805};
    host_vector(v1);
    wait_cycles(2 * CPB);
    checks++;
    if (avail_cnt - a0 !== 1 || rx_nums !== v1) begin
      failures++;
      $display("FAIL timeout_realign avail=%0d rx=%h expected 1 %h", avail_cnt - a0, rx_nums, v1);
    end
  endtask

  task automatic test_glitch();
    a0 = avail_cnt; e0 = err_cnt;
    host_rx = 1'b0;
    repeat (4) @(negedge clk);
    host_rx = 1'b1;
    wait_cycles(3 * CPB);
    checks++;
    if (err_cnt - e0 !== 1 || avail_cnt - a0 !== 0) begin
      failures++;
      $display("FAIL glitch_err err=%0d avail=%0d expected 1 0", err_cnt - e0, avail_cnt - a0);
    end
    v1 = {16'h0F0F, 16'hF0F0, 16'hC3C3, 16'h3C3C, 16'h9669};
    host_vector(v1);
    wait_cycles(2 * CPB);
    checks++;
    if (avail_cnt - a0 !== 1 || err_cnt - e0 !== 1 || rx_nums !== v1) begin
      failures++;
      $display("FAIL glitch_no_byte avail=%0d err=%0d rx=%h expected 1 1 %h",
               avail_cnt - a0, err_cnt - e0, rx_nums, v1);
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    a0 = avail_cnt; e0 = err_cnt;
    for (int i = 0; i < 3; i++) host_byte(8'h5A, 1'b1, 1'b0);
    host_byte(8'h3C, 1'b1, 1'b1);
    host_bit(1'b1);
    checks++;
    if (err_cnt - e0 !== 1 || avail_cnt - a0 !== 0) begin
      failures++;
      $display("FAIL parity_err err=%0d avail=%0d expected 1 0", err_cnt - e0, avail_cnt - a0);
    end
    v1 = {16'h1357, 16'h2468, 16'hACE0, 16'hBDF1, 16'h0102};
    host_vector(v1);
    wait_cycles(2 * CPB);
    checks++;
    if (avail_cnt - a0 !== 1 || rx_nums !== v1) begin
      failures++;
      $display("FAIL parity_recover avail=%0d rx=%h expected 1 %h", avail_cnt - a0, rx_nums, v1);
    end
  endtask
`endif

  task automatic test_reset_midframe();
    tx_nums = {16'hF6A5, 16'hFEDA, 16'hFD3C, 16'h00C1, 16'hDABE};
    pulse_send();
    wait_cycles(20);
    checks++;
    if (tx !== 1'b0 || tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL midframe_active tx=%b ready=%b expected 0 0", tx, tx_ready);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || rx_nums !== '0 || rx_error !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset tx=%b ready=%b rx=%h err=%b expected 1 1 0 0",
               tx, tx_ready, rx_nums, rx_error);
    end
    @(negedge clk) reset = 1'b0;
    wait_cycles(12 * CPB);
    checks++;
    if (tx !== 1'b1 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL midframe_stays_idle tx=%b ready=%b expected 1 1", tx, tx_ready);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back_ignore();
    test_framing();
    test_timeout();
    test_glitch();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
